// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Constants and helpers shared by the fetch stage and its queue.
//   The fetch entry type depends on XLEN, so it is declared inside
//   fetch_queue_unit from these constants.
// -----------------------------------------------------------------------------
package fetch_pkg;

  // Instruction word width and sequential PC increment in bytes
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  // A byte address is word-misaligned when either of its two low bits is set
  function automatic logic misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO with a single-cycle flush. The head entry is read
//   combinationally from storage, so there is no output register.
//   The caller qualifies enq/deq: enq is never asserted when the FIFO is full
//   without a simultaneous deq, and deq is never asserted when the FIFO is empty.
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-high reset (empties the FIFO)
//   flush      in   synchronous flush (empties the FIFO), same effect as reset
//   enq        in   write enq_data at the tail this cycle
//   enq_data   in   WIDTH-bit entry to write
//   deq        in   retire the head entry this cycle
//   head_data  out  WIDTH-bit head entry (don't-care while empty)
//   count      out  number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; an entry is only ever read after being written.
  // Writing into the slot being read by a full-queue dequeue is safe because
  // head_data reflects the old contents until the clock edge.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch stage: generates sequential PCs, reads a combinational
//   instruction memory and buffers {pc, instr} pairs for decode behind a
//   valid/ready handshake. A redirect flushes the queue, restarts fetch at the
//   word-aligned target and pulses misalign_err for one cycle if the target had
//   non-zero low bits.
// Ports
//   clk             in   clock, all state updates on posedge
//   reset           in   synchronous active-high reset
//   redirect_valid  in   branch/jump redirect request this cycle
//   redirect_pc     in   redirect target byte address
//   imem_addr       out  instruction memory byte address (= fetch_pc)
//   imem_rdata      in   instruction at imem_addr, same cycle
//   if_valid        out  queue head valid for decode
//   if_instr        out  head instruction
//   if_pc           out  head PC
//   if_ready        in   decode accepts the head this cycle
//   misalign_err    out  one-cycle pulse after a misaligned redirect
// -----------------------------------------------------------------------------
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               if_ready,
  output logic               misalign_err
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned     ENTRY_W    = $bits(fetch_entry_t);
  localparam int unsigned     CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] count;
  logic             deq;
  logic             can_enq;
  logic             enq;
  fetch_entry_t     enq_entry;
  fetch_entry_t     head_entry;

  // The head is killed combinationally during reset and redirect so that a
  // stale entry can never transfer in the cycle it is being discarded.
  assign if_valid = (count != '0) && !redirect_valid && !reset;
  assign deq      = if_valid && if_ready;

  // A full queue still accepts a new entry when the head leaves this cycle.
  assign can_enq  = (count < FULL_COUNT) || deq;
  assign enq      = can_enq && !redirect_valid && !reset;

  assign imem_addr       = fetch_pc;
  assign enq_entry.pc    = fetch_pc;
  assign enq_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .enq       (enq),
    .enq_data  (enq_entry),
    .deq       (deq),
    .head_data (head_entry),
    .count     (count)
  );

  assign if_pc    = head_entry.pc;
  assign if_instr = head_entry.instr;

  // PC generation: reset beats redirect, redirect beats sequential fetch.
  // The PC only advances when the current fetch was actually enqueued;
  // the +PC_STEP add wraps modulo 2^XLEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc     <= {redirect_pc[XLEN-1:2], 2'b00};
      misalign_err <= misaligned(redirect_pc[1:0]);
    end else begin
      if (can_enq) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
      misalign_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//   Scoreboard bench for fetch_queue_unit. The driver applies one cycle of
//   stimulus at each negedge and then advances a reference model that tracks
//   the next fetch address and a queue of {pc, instr} entries that decode
//   should see, in order. The monitor, one time step after the driver's
//   inputs settle, compares the DUT outputs with the model and pops the
//   expected head whenever decode accepts it.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int unsigned     XLEN     = 64;
  localparam int unsigned     DEPTH    = 4;
  localparam logic [63:0]     RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_ready;
  logic        misalign_err;

  fetch_queue_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .misalign_err   (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] imem_word(input logic [63:0] addr);
    return addr[31:0] ^ 32'hA5A5_0000;
  endfunction

  // Combinational instruction memory
  assign imem_rdata = imem_word(imem_addr);

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_pc;
  logic        exp_mis;
  bit          known;

  int unsigned n_checks;
  int unsigned n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, req, $time);
  endtask

  // Model of one clock edge. Runs after the monitor has retired any head that
  // decode accepted, so the queue size here already accounts for the dequeue.
  task automatic model_step(input logic rst, input logic rv, input logic [63:0] rpc);
    if (rst) begin
      exp_q.delete();
      m_pc    = RESET_PC;
      exp_mis = 1'b0;
      known   = 1'b1;
    end else if (rv) begin
      exp_q.delete();
      m_pc    = {rpc[63:2], 2'b00};
      exp_mis = (rpc[1:0] != 2'b00);
    end else begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back('{pc: m_pc, instr: imem_word(m_pc)});
        m_pc = m_pc + 64'd4;
      end
      exp_mis = 1'b0;
    end
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [63:0] rpc, input logic rst);
    @(negedge clk);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    #2;
    model_step(rst, rv, rpc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic exp_valid;
    #1;
    if (known) begin
      exp_valid = (exp_q.size() != 0) && !redirect_valid && !reset;
      check("if_valid", {63'd0, if_valid}, {63'd0, exp_valid});
      check("imem_addr", imem_addr, m_pc);
      check("misalign_err", {63'd0, misalign_err}, {63'd0, exp_mis});
      if (exp_valid) begin
        check("if_pc", if_pc, exp_q[0].pc);
        check("if_instr", {32'd0, if_instr}, {32'd0, exp_q[0].instr});
        if (if_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rpc;
    n_checks = 0;
    n_pass   = 0;
    known    = 1'b0;
    exp_mis  = 1'b0;
    m_pc     = '0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    // Streaming from reset with decode always ready; RESET_PC sits at the
    // top of the address space so the PC wraps through zero.
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1);
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b0);

    // Decode stalled for 10 cycles from release: queue fills, fetch holds.
    cycle(1'b0, 1'b0, '0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b0);

    // Redirect while the queue is full.
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 64'h100, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b0);

    // Misaligned redirect.
    cycle(1'b1, 1'b1, 64'h102, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b0);

    // Reset with entries queued and decode stalled.
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b0);

    // Randomised traffic: back-pressure, redirects (some misaligned, some near
    // the top of the address space) and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      else
        rpc = {32'($urandom), 32'($urandom)};
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            rpc,
            $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
